uart_cmd_decoder: RTL

//  Downstream of the UART RX FIFO: pops received bytes and decodes ASCII commands for the dual-watch core.

---
 rtl/uart_cmd_pkg.sv | 43 ++++
 rtl/uart_cmd_timeout.sv | 45 ++++
 rtl/uart_cmd_decoder.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared constants, state encoding and byte helpers for the UART command decoder.
package uart_cmd_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_T  = 8'h54;
  localparam logic [7:0] ASCII_R  = 8'h52;
  localparam logic [7:0] ASCII_C  = 8'h43;
  localparam logic [7:0] ASCII_M  = 8'h4D;
  localparam logic [7:0] ASCII_K  = 8'h4B;
  localparam logic [7:0] ASCII_QM = 8'h3F;
  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;

  localparam logic [4:0] MAX_HOUR       = 5'd23;
  localparam logic [5:0] MAX_MINSEC     = 6'd59;
  localparam logic [2:0] LAST_DIGIT_IDX = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIGITS = 2'd1,
    ST_TERM   = 2'd2
  } cmd_state_e;

  function automatic logic [7:0] ascii_upper(input logic [7:0] b);
    if ((b >= 8'h61) && (b <= 8'h7A)) begin
      return b - 8'h20;
    end else begin
      return b;
    end
  endfunction

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_9);
  endfunction

  // Two decimal digits to binary; 99 max fits in 7 bits.
  function automatic logic [6:0] bcd_pair(input logic [3:0] tens, input logic [3:0] ones);
    return (7'(tens) * 7'd10) + 7'(ones);
  endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte idle counter: clears on clear, counts while enabled, pulses expire at TIMEOUT_CYC-1.
module uart_cmd_timeout
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_r;
  logic             expire_s;

  // A clear in the expiry cycle suppresses the pulse, so a late byte still wins.
  always_comb begin
    expire_s = 1'b0;
    if (enable && !clear && (cnt_r == CNT_LAST)) begin
      expire_s = 1'b1;
    end else begin
      expire_s = 1'b0;
    end
  end

  // Idle-cycle counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= '0;
    end else if (clear || expire_s) begin
      cnt_r <= '0;
    end else if (enable) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= '0;
    end
  end

  assign expire = expire_s;

endmodule

// File: rtl/uart_cmd_decoder.sv
// Pops RX FIFO bytes and decodes single-byte control commands and "Thhmmss<CR>" time loads.
// Optional ACK byte stream to the TX FIFO is enabled by defining UART_CMD_ACK_EN.
module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] fifo_rdata,
  input  logic       fifo_empty,
  output logic       fifo_pop,
  output logic       run_pulse,
  output logic       clear_pulse,
  output logic       mode_pulse,
  output logic       set_valid,
  output logic [4:0] set_hour,
  output logic [5:0] set_min,
  output logic [5:0] set_sec,
  output logic       cmd_err,
  output logic       ack_push,
  output logic [7:0] ack_data,
  input  logic       ack_full
);

  cmd_state_e state_r, state_nxt_s;
  logic [2:0] idx_r, idx_nxt_s;
  logic [3:0] digit_r [6];

  logic       pop_s;
  logic [7:0] byte_up_s;
  logic       expire_s;
  logic       dig_we_s;
  logic       run_s, clear_s, mode_s, set_s, err_s;
  logic [6:0] hour_bin_s, min_bin_s, sec_bin_s;
  logic       time_ok_s;

  logic       run_pulse_r, clear_pulse_r, mode_pulse_r, set_valid_r, cmd_err_r;
  logic [4:0] set_hour_r;
  logic [5:0] set_min_r, set_sec_r;

  assign pop_s     = !fifo_empty;
  assign fifo_pop  = pop_s;
  assign byte_up_s = ascii_upper(fifo_rdata);

  assign hour_bin_s = bcd_pair(digit_r[0], digit_r[1]);
  assign min_bin_s  = bcd_pair(digit_r[2], digit_r[3]);
  assign sec_bin_s  = bcd_pair(digit_r[4], digit_r[5]);
  assign time_ok_s  = (hour_bin_s <= {2'b00, MAX_HOUR}) &&
                      (min_bin_s  <= {1'b0, MAX_MINSEC}) &&
                      (sec_bin_s  <= {1'b0, MAX_MINSEC});

  uart_cmd_timeout #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (pop_s || (state_r == ST_IDLE)),
    .enable (state_r != ST_IDLE),
    .expire (expire_s)
  );

  // Next-state and per-byte decode.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    dig_we_s    = 1'b0;
    run_s       = 1'b0;
    clear_s     = 1'b0;
    mode_s      = 1'b0;
    set_s       = 1'b0;
    err_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pop_s) begin
          case (byte_up_s)
            ASCII_R:  run_s   = 1'b1;
            ASCII_C:  clear_s = 1'b1;
            ASCII_M:  mode_s  = 1'b1;
            ASCII_T: begin
              state_nxt_s = ST_DIGITS;
              idx_nxt_s   = 3'd0;
            end
            ASCII_CR, ASCII_LF, ASCII_SP: err_s = 1'b0;
            default:  err_s   = 1'b1;
          endcase
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_DIGITS: begin
        if (pop_s) begin
          if (is_digit(fifo_rdata)) begin
            dig_we_s = 1'b1;
            if (idx_r == LAST_DIGIT_IDX) begin
              state_nxt_s = ST_TERM;
              idx_nxt_s   = 3'd0;
            end else begin
              idx_nxt_s = idx_r + 3'd1;
            end
          end else begin
            err_s       = 1'b1;
            state_nxt_s = ST_IDLE;
            idx_nxt_s   = 3'd0;
          end
        end else if (expire_s) begin
          err_s       = 1'b1;
          state_nxt_s = ST_IDLE;
          idx_nxt_s   = 3'd0;
        end else begin
          state_nxt_s = ST_DIGITS;
        end
      end
      ST_TERM: begin
        if (pop_s) begin
          if (fifo_rdata == ASCII_CR) begin
            if (time_ok_s) begin
              set_s = 1'b1;
            end else begin
              err_s = 1'b1;
            end
          end else begin
            err_s = 1'b1;
          end
          state_nxt_s = ST_IDLE;
          idx_nxt_s   = 3'd0;
        end else if (expire_s) begin
          err_s       = 1'b1;
          state_nxt_s = ST_IDLE;
          idx_nxt_s   = 3'd0;
        end else begin
          state_nxt_s = ST_TERM;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        idx_nxt_s   = 3'd0;
      end
    endcase
  end

  // State, digit buffer and registered command outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      idx_r         <= 3'd0;
      for (int i = 0; i < 6; i++) begin
        digit_r[i] <= 4'd0;
      end
      run_pulse_r   <= 1'b0;
      clear_pulse_r <= 1'b0;
      mode_pulse_r  <= 1'b0;
      set_valid_r   <= 1'b0;
      cmd_err_r     <= 1'b0;
      set_hour_r    <= 5'd0;
      set_min_r     <= 6'd0;
      set_sec_r     <= 6'd0;
    end else begin
      state_r       <= state_nxt_s;
      idx_r         <= idx_nxt_s;
      if (dig_we_s) begin
        digit_r[idx_r] <= fifo_rdata[3:0];
      end
      run_pulse_r   <= run_s;
      clear_pulse_r <= clear_s;
      mode_pulse_r  <= mode_s;
      set_valid_r   <= set_s;
      cmd_err_r     <= err_s;
      if (set_s) begin
        set_hour_r <= hour_bin_s[4:0];
        set_min_r  <= min_bin_s[5:0];
        set_sec_r  <= sec_bin_s[5:0];
      end
    end
  end

  assign run_pulse   = run_pulse_r;
  assign clear_pulse = clear_pulse_r;
  assign mode_pulse  = mode_pulse_r;
  assign set_valid   = set_valid_r;
  assign cmd_err     = cmd_err_r;
  assign set_hour    = set_hour_r;
  assign set_min     = set_min_r;
  assign set_sec     = set_sec_r;

`ifdef UART_CMD_ACK_EN
  logic       ack_push_r;
  logic [7:0] ack_data_r;

  // Ack follows each result pulse by one cycle; a full TX FIFO drops it silently.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack_push_r <= 1'b0;
      ack_data_r <= 8'h00;
    end else begin
      ack_push_r <= (run_pulse_r || clear_pulse_r || mode_pulse_r || set_valid_r || cmd_err_r) && !ack_full;
      ack_data_r <= cmd_err_r ? ASCII_QM : ASCII_K;
    end
  end

  assign ack_push = ack_push_r;
  assign ack_data = ack_data_r;
`else
  logic unused_ack_full_s;
  assign unused_ack_full_s = ack_full;
  assign ack_push = 1'b0;
  assign ack_data = 8'h00;
`endif

endmodule
